subtrator_serial: RTL and testbench
===================================

SUBTRATOR_SERIAL -- requirements
Module: subtrator_serial

Interface
REQ-001 SHALL provide parameter: N, 8, operand/result width in bits (N >= 1).
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL provide port: inicio  input  1  start request; sampled on the rising edge.
REQ-005 SHALL provide port: A  input  N  minuend; sampled with inicio.
REQ-006 SHALL provide port: B  input  N  subtrahend; sampled with inicio.
REQ-007 SHALL provide port: Te  input  1  borrow-in; sampled with inicio.
REQ-008 SHALL provide port: S  output  N  registered difference A - B - Te mod 2^N.
REQ-009 SHALL provide port: Ts  output  1  registered final borrow-out.
REQ-010 SHALL provide port: ovf  output  1  registered signed (two's complement) overflow.
REQ-011 SHALL provide port: ocupado  output  1  high while bits are being processed.
REQ-012 SHALL provide port: pronto  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement a 3-state FSM: OCIOSO, CALCULA, FIM.
REQ-014 In OCIOSO with inicio=1 at an edge, SHALL do the following on that edge:
- capture A, B and Te into internal shift and borrow registers;
- clear the bit counter;
- go to CALCULA.
REQ-015 In OCIOSO with inicio=0, SHALL remain in OCIOSO with all outputs held.
REQ-016 In CALCULA, SHALL process exactly one bit per edge, LSB first, with a0, b0 the current operand LSBs and bw the borrow register:
- difference bit d = a0 ^ b0 ^ bw;
- next borrow bw' = (~a0 & b0) | (~(a0 ^ b0) & bw);
- d shifts into the result register from the MSB side.
REQ-017 On the N-th CALCULA edge, SHALL do the following:
- load S with the full result;
- load Ts with the final borrow;
- load ovf with (borrow into bit N-1) XOR (final borrow);
- go to FIM.
REQ-018 Timing, with the inicio-sampling edge as edge 0:
- ocupado SHALL be 1 exactly while in CALCULA (after edge 0 through edge N);
- pronto SHALL be 1 exactly while in FIM (after edge N, for one cycle);
- FIM SHALL return to OCIOSO on the next edge.
REQ-019 Total latency from the inicio-sampling edge to the assertion of pronto SHALL be N edges.
REQ-020 inicio SHALL be ignored in CALCULA and FIM; operands changing during an operation SHALL NOT affect the result.
REQ-021 S, Ts and ovf SHALL change only on the N-th CALCULA edge, and SHALL hold until the next completion or reset.
REQ-022 With inicio held continuously at 1, SHALL start a new operation every N+2 cycles.
REQ-023 With N=1, SHALL behave as a registered 1-bit full subtractor with pronto 1 edge after the start edge.

Reset
REQ-024 rst_n=0 SHALL immediately, without waiting for clk, force the following:
- state to OCIOSO;
- S, Ts, ovf, ocupado and pronto to 0;
- shift registers, borrow register and counter to 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no pronto pulse.
REQ-026 The first inicio sampled after rst_n returns high SHALL start a normal operation.

Verification (N=8)
REQ-027 A=0x05, B=0x03, Te=0 -> S=0x02, Ts=0, ovf=0; ocupado high for 8 cycles; pronto high for 1 cycle, 8 edges after the start edge.
REQ-028 A=0x00, B=0x01, Te=0 -> S=0xFF, Ts=1, ovf=0.
REQ-029 A=0x80, B=0x01, Te=0 -> S=0x7F, Ts=0, ovf=1. A=0x10, B=0x10, Te=1 -> S=0xFF, Ts=1, ovf=0.
REQ-030 Extra inicio pulses and operand changes during ocupado -> result of the first operation only, single pronto pulse.
REQ-031 rst_n low 4 cycles into an operation -> all outputs 0 asynchronously, no pronto; next start A=0x09, B=0x04 -> S=0x05.
REQ-032 inicio held at 1 with fixed operands -> pronto pulses exactly 10 cycles apart; S stable and correct at every pulse.

Source files
------------

// File: rtl/subtrator_serial.sv
`default_nettype none
// ============================================================================
// Module   : subtrator_serial
// Purpose  : Bit-serial N-bit subtractor computing S = A - B - Te (mod 2^N).
//            One bit per clock, LSB first. Reports the final borrow (Ts) and
//            two's-complement overflow (ovf).
// Ports    : clk      - clock, rising edge
//            rst_n    - asynchronous active-low reset
//            inicio   - start request, sampled only while idle
//            A, B, Te - minuend, subtrahend and borrow-in, sampled with inicio
//            S        - registered difference
//            Ts       - registered final borrow-out
//            ovf      - registered signed overflow
//            ocupado  - high while bits are being processed
//            pronto   - one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module subtrator_serial #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inicio,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Te,
  output logic [N-1:0] S,
  output logic         Ts,
  output logic         ovf,
  output logic         ocupado,
  output logic         pronto
);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] CALCULA = 2'd1;
  localparam logic [1:0] FIM     = 2'd2;

  // Counter only needs to reach N-1; keep at least one bit for N=1.
  localparam int             CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  logic [1:0]    state;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [N-1:0]  res;
  logic          bw;
  logic [CW-1:0] cnt;

  logic          d;
  logic          bw_next;
  logic [N-1:0]  res_next;

  always_comb begin
    d       = a_sh[0] ^ b_sh[0] ^ bw;
    bw_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bw);
  end

  // New difference bit enters at the MSB; after N shifts the LSB of the
  // result has arrived at bit 0.
  generate
    if (N == 1) begin : g_res_single
      assign res_next = d;
    end else begin : g_res_wide
      assign res_next = {d, res[N-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OCIOSO;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      bw    <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      Ts    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        OCIOSO: begin
          if (inicio) begin
            a_sh  <= A;
            b_sh  <= B;
            bw    <= Te;
            cnt   <= '0;
            state <= CALCULA;
          end
        end
        CALCULA: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          bw   <= bw_next;
          res  <= res_next;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            S     <= res_next;
            Ts    <= bw_next;
            // bw here is the borrow into the sign bit.
            ovf   <= bw ^ bw_next;
            state <= FIM;
          end
        end
        FIM: begin
          state <= OCIOSO;
        end
        default: begin
          state <= OCIOSO;
        end
      endcase
    end
  end

  // Moore decodes of the state register, so both flags are glitch-free
  // and drop to 0 the instant reset asserts.
  assign ocupado = (state == CALCULA);
  assign pronto  = (state == FIM);

endmodule
`default_nettype wire

// File: tb/tb_subtrator_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_subtrator_serial
// Purpose  : Self-checking bench for subtrator_serial (N=8): table of
//            hand-computed vectors plus sequences for busy-time stimulus,
//            mid-operation reset and back-to-back starts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_subtrator_serial;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         inicio;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Te;
  logic [N-1:0] S;
  logic         Ts;
  logic         ovf;
  logic         ocupado;
  logic         pronto;

  int checks = 0;
  int errors = 0;

  subtrator_serial #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inicio  (inicio),
    .A       (A),
    .B       (B),
    .Te      (Te),
    .S       (S),
    .Ts      (Ts),
    .ovf     (ovf),
    .ocupado (ocupado),
    .pronto  (pronto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       te;
    logic [7:0] s;
    logic       ts;
    logic       ov;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic te);
    @(negedge clk);
    A = a; B = b; Te = te; inicio = 1'b1;
    @(posedge clk);
    #1 inicio = 1'b0;
  endtask

  // Observes each negedge after the start edge; k = edges elapsed since it.
  task automatic wait_done(output int busy, output int lat, output logic done);
    busy = 0; lat = -1; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (ocupado) busy++;
      if (pronto) begin
        lat  = k;
        done = 1'b1;
      end
    end
  endtask

  initial begin
    int   busy, lat;
    logic done;
    int   pulses;
    int   last_k;
    logic [7:0] s_at;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};
    vecs[7] = '{8'hC8, 8'h37, 1'b0, 8'h91, 1'b0, 1'b0};

    rst_n = 1'b1; inicio = 1'b0; A = '0; B = '0; Te = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_S", S, 0);
    chk("reset_Ts", Ts, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_ocupado", ocupado, 0);
    chk("reset_pronto", pronto, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle with inicio low: nothing moves.
    repeat (3) @(negedge clk);
    chk("idle_ocupado", ocupado, 0);
    chk("idle_pronto", pronto, 0);

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].te);
      wait_done(busy, lat, done);
      chk($sformatf("v%0d_done", i), done, 1);
      chk($sformatf("v%0d_latency", i), lat, 8);
      chk($sformatf("v%0d_busy_cycles", i), busy, 8);
      chk($sformatf("v%0d_S", i), S, vecs[i].s);
      chk($sformatf("v%0d_Ts", i), Ts, vecs[i].ts);
      chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ov);
      @(negedge clk);
      chk($sformatf("v%0d_pronto_width", i), pronto, 0);
      chk($sformatf("v%0d_S_hold", i), S, vecs[i].s);
    end

    // Extra inicio pulses and operand changes while busy.
    start_op(8'h05, 8'h03, 1'b0);
    pulses = 0; s_at = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pronto) begin
        pulses++;
        s_at = S;
      end
      if (k < 4) begin
        A = 8'($urandom); B = 8'($urandom); Te = 1'($urandom);
        inicio = (k % 2 == 0);
      end else begin
        inicio = 1'b0;
      end
    end
    chk("busy_ignore_pulses", pulses, 1);
    chk("busy_ignore_S", s_at, 8'h02);

    // Reset four cycles into an operation.
    start_op(8'h33, 8'h11, 1'b0);
    repeat (4) @(negedge clk);
    chk("pre_abort_ocupado", ocupado, 1);
    chk("pre_abort_S", S, 8'h02);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_S", S, 0);
    chk("abort_Ts", Ts, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_ocupado", ocupado, 0);
    chk("abort_pronto", pronto, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (pronto) pulses++;
    end
    chk("abort_no_pronto", pulses, 0);
    start_op(8'h09, 8'h04, 1'b0);
    wait_done(busy, lat, done);
    chk("post_reset_done", done, 1);
    chk("post_reset_S", S, 8'h05);
    chk("post_reset_Ts", Ts, 0);

    // inicio held high: completions every N+2 cycles.
    @(negedge clk);
    A = 8'h0C; B = 8'h05; Te = 1'b0; inicio = 1'b1;
    pulses = 0; last_k = -1;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (pronto) begin
        pulses++;
        chk("stream_S", S, 8'h07);
        if (last_k >= 0) chk("stream_period", k - last_k, 10);
        last_k = k;
      end
    end
    inicio = 1'b0;
    chk("stream_pulse_count", pulses >= 4, 1);

    repeat (12) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
